bellek_erisim: RTL
==================

// Module: bellek_erisim
// PURPOSE
//  Memory-access stage directly downstream of the execute stage (yurut). Takes the registered
//  execute result (rd address, rd value, write-enable) plus load/store control, drives a
//  single-outstanding data-memory request/ready handshake, aligns and extends load data, and
//  delivers a one-cycle-valid writeback packet to the geri_yaz stage. Stalls upstream while busy.
// PARAMETERS
//  BEKLEME_SINIRI  255  max cycles in BEKLE before the access is aborted (8-bit counter)
// PORTS
//  clk_i              in   1   clock, rising edge
//  rst_i              in   1   asynchronous reset, active-low
//  gecerli_i          in   1   upstream packet valid
//  durdur_o           out  1   stall to upstream; packet not accepted while 1
//  rd_adres_i         in   5   destination register
//  rd_deger_i         in   32  execute result; effective address for load/store
//  yaz_yazmac_i       in   1   register write request from execute
//  bellek_oku_i       in   1   load
//  bellek_yaz_i       in   1   store
//  bellek_boyut_i     in   2   00 byte, 01 half, 10 word, 11 reserved
//  isaretsiz_i        in   1   load zero-extends when 1, sign-extends when 0
//  yazilacak_deger_i  in   32  store data (rs2)
//  veri_istek_o       out  1   memory request
//  veri_yaz_o         out  1   1 = write, 0 = read
//  veri_adres_o       out  32  {addr[31:2],2'b00}
//  veri_maske_o       out  4   byte enables
//  veri_yaz_deger_o   out  32  lane-replicated store data
//  veri_hazir_i       in   1   memory ready/complete (read data valid same cycle)
//  veri_oku_deger_i   in   32  read word
//  gecerli_o          out  1   writeback packet valid (1-cycle pulse)
//  rd_adres_o         out  5   destination register
//  rd_deger_o         out  32  writeback value
//  yaz_yazmac_o       out  1   register write enable
//  hizasiz_hata_o     out  1   misaligned/reserved-size pulse
//  zaman_asimi_o      out  1   timeout pulse
// BEHAVIOUR
//  - Reset (rst_i=0, async): state BOSTA, counter 0, every output 0. Mid-access reset drops the request.
//  - States: BOSTA, BEKLE. durdur_o = (state==BEKLE). Accept = gecerli_i & state==BOSTA.
//  - Non-memory accept: next edge gecerli_o=1, rd_*_o = inputs, latency 1, stays BOSTA.
//  - bellek_yaz_i & bellek_oku_i both 1: handled as store.
//  - Alignment error (half with addr[0]=1, word with addr[1:0]!=0, or size 11): no request; next edge
//    gecerli_o=1, yaz_yazmac_o=0, hizasiz_hata_o=1 for one cycle; stays BOSTA.
//  - Aligned memory accept: next edge enter BEKLE, veri_istek_o=1 with captured address/mask/data,
//    counter cleared; request signals held constant until veri_hazir_i or abort.
//  - Store mask: byte 1<<a[1:0], half a[1]?1100:0011, word 1111. Data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
//  - BEKLE & veri_hazir_i: next edge veri_istek_o=0, state BOSTA, gecerli_o=1. Load: rd_deger_o =
//    (veri_oku_deger_i >> 8*a[1:0]) truncated to size, sign/zero-extended per isaretsiz. Store: yaz_yazmac_o=0.
//  - BEKLE, no ready: counter++; when counter==BEKLEME_SINIRI-1 with no ready: next edge BOSTA,
//    veri_istek_o=0, gecerli_o=1, yaz_yazmac_o=0, zaman_asimi_o=1 one cycle. Ready on that same cycle wins.
//  - yaz_yazmac_o always 0 when rd_adres_o==0 or the op is a store, else equals captured yaz_yazmac_i.
//  - Minimum load/store latency accept->gecerli_o: 2 cycles (ready on first BEKLE cycle). New packet
//    accepted the cycle after returning to BOSTA. gecerli_o, error pulses deassert the cycle after.
//  - veri_hazir_i outside BEKLE ignored.
// TESTING
//  - ALU op rd=5 val=0x1234, yaz=1 -> next cycle gecerli_o=1, rd_adres_o=5, rd_deger_o=0x1234, durdur_o=0.
//  - lb addr=0x1003, mem word 0x80FF_0000, ready after 3 cycles -> rd_deger_o=0xFFFFFF80, durdur_o high 3+1 cycles;
//    lbu same -> 0x00000080.
//  - sh addr=0x2002 data=0xABCD_1234 -> veri_adres_o=0x2000, mask=1100, veri_yaz_deger_o=0x12341234, yaz_yazmac_o=0.
//  - lw addr=0x3001 -> no veri_istek_o, hizasiz_hata_o pulse, yaz_yazmac_o=0; load rd=0 -> yaz_yazmac_o=0.
//  - lw, veri_hazir_i never asserted -> zaman_asimi_o pulse after BEKLEME_SINIRI cycles, state BOSTA, durdur_o=0.
//  - rst_i low during BEKLE -> all outputs 0 immediately; after release, an ALU op passes in 1 cycle.

Source files
------------

// File: rtl/bellek_erisim.sv
// Memory-access stage: single-outstanding data-memory handshake, load alignment/extension,
// and a one-cycle writeback packet toward geri_yaz. Stalls upstream while an access is open.
module bellek_erisim #(
  parameter int BEKLEME_SINIRI = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        gecerli_i,
  output logic        durdur_o,
  input  logic [4:0]  rd_adres_i,
  input  logic [31:0] rd_deger_i,
  input  logic        yaz_yazmac_i,
  input  logic        bellek_oku_i,
  input  logic        bellek_yaz_i,
  input  logic [1:0]  bellek_boyut_i,
  input  logic        isaretsiz_i,
  input  logic [31:0] yazilacak_deger_i,
  output logic        veri_istek_o,
  output logic        veri_yaz_o,
  output logic [31:0] veri_adres_o,
  output logic [3:0]  veri_maske_o,
  output logic [31:0] veri_yaz_deger_o,
  input  logic        veri_hazir_i,
  input  logic [31:0] veri_oku_deger_i,
  output logic        gecerli_o,
  output logic [4:0]  rd_adres_o,
  output logic [31:0] rd_deger_o,
  output logic        yaz_yazmac_o,
  output logic        hizasiz_hata_o,
  output logic        zaman_asimi_o
);

  typedef enum logic {BOSTA = 1'b0, BEKLE = 1'b1} durum_t;

  localparam logic [7:0] SON_SAYIM = 8'(BEKLEME_SINIRI - 1);

  durum_t      durum_q, durum_d;
  logic [7:0]  sayac_q;
  logic [4:0]  rd_q;
  logic        yaz_q, depo_q, isaretsiz_q;
  logic [1:0]  boyut_q, ofs_q;

  logic        kabul, bellek_op, hizasiz, tamam, asim;
  logic [3:0]  maske;
  logic [31:0] yaz_deger, kaydir, yuk_deger;

  assign durdur_o = (durum_q == BEKLE);

  // Request decode straight from the incoming packet
  always_comb begin
    bellek_op = bellek_oku_i | bellek_yaz_i;
    hizasiz   = 1'b0;
    maske     = 4'b0000;
    yaz_deger = 32'h0;
    case (bellek_boyut_i)
      2'b00: begin
        maske     = 4'b0001 << rd_deger_i[1:0];
        yaz_deger = {4{yazilacak_deger_i[7:0]}};
      end
      2'b01: begin
        hizasiz   = rd_deger_i[0];
        maske     = rd_deger_i[1] ? 4'b1100 : 4'b0011;
        yaz_deger = {2{yazilacak_deger_i[15:0]}};
      end
      2'b10: begin
        hizasiz   = |rd_deger_i[1:0];
        maske     = 4'b1111;
        yaz_deger = yazilacak_deger_i;
      end
      default: hizasiz = 1'b1;
    endcase
  end

  // Load data: bring the addressed lane to bit 0, then extend
  always_comb begin
    kaydir = veri_oku_deger_i >> {ofs_q, 3'b000};
    case (boyut_q)
      2'b00:   yuk_deger = {{24{~isaretsiz_q & kaydir[7]}}, kaydir[7:0]};
      2'b01:   yuk_deger = {{16{~isaretsiz_q & kaydir[15]}}, kaydir[15:0]};
      default: yuk_deger = kaydir;
    endcase
  end

  always_comb begin
    kabul   = gecerli_i & (durum_q == BOSTA);
    tamam   = (durum_q == BEKLE) & veri_hazir_i;
    asim    = (durum_q == BEKLE) & ~veri_hazir_i & (sayac_q == SON_SAYIM);
    durum_d = durum_q;
    case (durum_q)
      BOSTA: if (kabul & bellek_op & ~hizasiz) durum_d = BEKLE;
      BEKLE: if (tamam | asim) durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) durum_q <= BOSTA;
    else        durum_q <= durum_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sayac_q          <= 8'd0;
      rd_q             <= 5'd0;
      yaz_q            <= 1'b0;
      depo_q           <= 1'b0;
      isaretsiz_q      <= 1'b0;
      boyut_q          <= 2'b00;
      ofs_q            <= 2'b00;
      veri_istek_o     <= 1'b0;
      veri_yaz_o       <= 1'b0;
      veri_adres_o     <= 32'h0;
      veri_maske_o     <= 4'h0;
      veri_yaz_deger_o <= 32'h0;
      gecerli_o        <= 1'b0;
      rd_adres_o       <= 5'd0;
      rd_deger_o       <= 32'h0;
      yaz_yazmac_o     <= 1'b0;
      hizasiz_hata_o   <= 1'b0;
      zaman_asimi_o    <= 1'b0;
    end else begin
      gecerli_o      <= 1'b0;
      yaz_yazmac_o   <= 1'b0;
      hizasiz_hata_o <= 1'b0;
      zaman_asimi_o  <= 1'b0;
      if (durum_q == BOSTA) begin
        if (kabul) begin
          if (!bellek_op) begin
            gecerli_o    <= 1'b1;
            rd_adres_o   <= rd_adres_i;
            rd_deger_o   <= rd_deger_i;
            yaz_yazmac_o <= yaz_yazmac_i & (rd_adres_i != 5'd0);
          end else if (hizasiz) begin
            gecerli_o      <= 1'b1;
            rd_adres_o     <= rd_adres_i;
            rd_deger_o     <= 32'h0;
            hizasiz_hata_o <= 1'b1;
          end else begin
            // Store wins when both load and store are flagged
            veri_istek_o     <= 1'b1;
            veri_yaz_o       <= bellek_yaz_i;
            veri_adres_o     <= {rd_deger_i[31:2], 2'b00};
            veri_maske_o     <= maske;
            veri_yaz_deger_o <= yaz_deger;
            sayac_q          <= 8'd0;
            rd_q             <= rd_adres_i;
            yaz_q            <= yaz_yazmac_i & (rd_adres_i != 5'd0) & ~bellek_yaz_i;
            depo_q           <= bellek_yaz_i;
            isaretsiz_q      <= isaretsiz_i;
            boyut_q          <= bellek_boyut_i;
            ofs_q            <= rd_deger_i[1:0];
          end
        end
      end else if (tamam | asim) begin
        veri_istek_o     <= 1'b0;
        veri_yaz_o       <= 1'b0;
        veri_adres_o     <= 32'h0;
        veri_maske_o     <= 4'h0;
        veri_yaz_deger_o <= 32'h0;
        gecerli_o        <= 1'b1;
        rd_adres_o       <= rd_q;
        // Ready on the final counted cycle still completes normally
        rd_deger_o       <= (tamam & ~depo_q) ? yuk_deger : 32'h0;
        yaz_yazmac_o     <= tamam & yaz_q;
        zaman_asimi_o    <= asim;
      end else begin
        sayac_q <= sayac_q + 8'd1;
      end
    end
  end

endmodule
